// File: rtl/player_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : player_lane_ctrl
// Purpose  : Player lane selector with move cooldown, hit lockout and a
//            registered active-low 7-segment lane indicator.
//            Optional macro PLAYER_BLINK_EN blinks the indicator during HIT.
// Revision : 1.0  initial release
// ============================================================================
module player_lane_ctrl #(
    parameter int LANES      = 2,
    parameter int START_LANE = 0,
    parameter int WRAP       = 0,
    parameter int COOLDOWN   = 4,
    parameter int HIT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       hit,
    output logic [1:0] lane,
    output logic [6:0] seg,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_COOL  = 2'd2,
        ST_HIT   = 2'd3
    } state_t;

    localparam logic [1:0] c_START = 2'(START_LANE);
    localparam logic [1:0] c_LAST  = 2'(LANES - 1);
    localparam logic [7:0] c_COOL  = 8'(COOLDOWN);
    localparam logic [7:0] c_HIT   = 8'(HIT_CYCLES);
    localparam logic [6:0] c_BLANK = 7'b1111111;

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] r_lane;
    logic [1:0] w_nextLane;
    logic [7:0] r_cnt;
    logic [7:0] w_nextCnt;
    logic [6:0] r_seg;
    logic [6:0] w_nextSeg;

    function automatic logic [6:0] lanePattern(input logic [1:0] idx);
        case (idx)
            2'd0:    lanePattern = 7'b0011100;
            2'd1:    lanePattern = 7'b0100011;
            2'd2:    lanePattern = 7'b1110111;
            default: lanePattern = 7'b1111110;
        endcase
    endfunction

    always_comb begin
        w_nextState = r_state;
        w_nextLane  = r_lane;
        w_nextCnt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_nextState = ST_READY;
                w_nextLane  = c_START;
                w_nextCnt   = '0;
            end
            ST_READY: begin
                // Hit wins over any move presented in the same cycle.
                if (hit) begin
                    w_nextState = ST_HIT;
                    w_nextCnt   = c_HIT;
                end else if (move_up && !move_down) begin
                    if (r_lane != 2'd0) begin
                        w_nextLane  = r_lane - 2'd1;
                        w_nextState = ST_COOL;
                        w_nextCnt   = c_COOL;
                    end else if (WRAP != 0) begin
                        w_nextLane  = c_LAST;
                        w_nextState = ST_COOL;
                        w_nextCnt   = c_COOL;
                    end
                end else if (move_down && !move_up) begin
                    if (r_lane != c_LAST) begin
                        w_nextLane  = r_lane + 2'd1;
                        w_nextState = ST_COOL;
                        w_nextCnt   = c_COOL;
                    end else if (WRAP != 0) begin
                        w_nextLane  = 2'd0;
                        w_nextState = ST_COOL;
                        w_nextCnt   = c_COOL;
                    end
                end
            end
            ST_COOL, ST_HIT: begin
                if (hit) begin
                    w_nextState = ST_HIT;
                    w_nextCnt   = c_HIT;
                end else if (r_cnt <= 8'd1) begin
                    w_nextState = ST_READY;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_nextState = ST_INIT;
                w_nextLane  = c_START;
                w_nextCnt   = '0;
            end
        endcase
    end

`ifdef PLAYER_BLINK_EN
    logic [1:0] r_blink;
    logic [1:0] w_nextBlink;

    // Two-cycle phases: blank on HIT entry, then lane pattern, and so on.
    always_comb begin
        w_nextBlink = (r_state == ST_HIT) ? r_blink + 2'd1 : 2'd0;
        if (w_nextState == ST_INIT) begin
            w_nextSeg = c_BLANK;
        end else if (w_nextState == ST_HIT && !w_nextBlink[1]) begin
            w_nextSeg = c_BLANK;
        end else begin
            w_nextSeg = lanePattern(r_lane);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_blink <= 2'd0;
        end else begin
            r_blink <= w_nextBlink;
        end
    end
`else
    // Built from the current lane so the indicator trails a lane change by one cycle.
    always_comb begin
        w_nextSeg = (w_nextState == ST_INIT) ? c_BLANK : lanePattern(r_lane);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_lane  <= c_START;
            r_cnt   <= '0;
            r_seg   <= c_BLANK;
        end else begin
            r_state <= w_nextState;
            r_lane  <= w_nextLane;
            r_cnt   <= w_nextCnt;
            r_seg   <= w_nextSeg;
        end
    end

    assign lane = r_lane;
    assign seg  = r_seg;
    assign busy = (r_state == ST_COOL) || (r_state == ST_HIT);

endmodule
`default_nettype wire

// File: doc/player_lane_ctrl.md
PLAYER_LANE_CTRL -- requirements
Module: player_lane_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 2, number of player lanes, legal range 2..4.
REQ-002 SHALL have parameter START_LANE, default 0, lane entered on leaving INIT, legal range 0..LANES-1.
REQ-003 SHALL have parameter WRAP, default 0; 0 = saturate at the end lanes, 1 = wrap around.
REQ-004 SHALL have parameter COOLDOWN, default 4, lockout cycles after an accepted move, legal range 1..255.
REQ-005 SHALL have parameter HIT_CYCLES, default 16, length of the hit state in cycles, legal range 1..255.
REQ-006 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have port move_up, input, 1 bit, single-cycle pulse requesting lane-1.
REQ-009 SHALL have port move_down, input, 1 bit, single-cycle pulse requesting lane+1.
REQ-010 SHALL have port hit, input, 1 bit, single-cycle collision pulse.
REQ-011 SHALL have port lane, output, 2 bits, current lane index.
REQ-012 SHALL have port seg, output, 7 bits, active-low 7-segment pattern, bit6..0 = g..a.
REQ-013 SHALL have port busy, output, 1 bit, high while in COOLDOWN or HIT.

Function
REQ-014 SHALL implement states INIT, READY, COOLDOWN and HIT, all registered on clk.
REQ-015 SHALL, in INIT, drive seg=7'b1111111 and lane=START_LANE, and go to READY on the next cycle.
REQ-016 SHALL drive seg by lane: 0 = 7'b0011100; 1 = 7'b0100011; 2 = 7'b1110111; 3 = 7'b1111110.
REQ-017 SHALL register seg, so seg reflects a lane change one cycle after lane changes.
REQ-018 SHALL, in READY with move_up=1 and move_down=0, set lane to lane-1 and enter COOLDOWN.
REQ-019 SHALL, in READY with move_down=1 and move_up=0, set lane to lane+1 and enter COOLDOWN.
REQ-020 SHALL, with WRAP=0, ignore a move past lane 0 or lane LANES-1: lane is unchanged and the state stays READY.
REQ-021 SHALL, with WRAP=1, wrap moves: 0-1 gives LANES-1, and LANES-1+1 gives 0.
REQ-022 SHALL ignore move_up and move_down asserted in the same cycle.
REQ-023 SHALL load a counter with COOLDOWN on entering COOLDOWN, decrement it each cycle, and return to READY when it reaches 0.
REQ-024 SHALL drop all move requests in COOLDOWN and HIT; requests are not queued.
REQ-025 SHALL, on hit=1 in READY or COOLDOWN, enter HIT and load a counter with HIT_CYCLES.
REQ-026 SHALL give hit priority over a move in the same cycle; lane is unchanged.
REQ-027 SHALL, on hit=1 while in HIT, reload the counter with HIT_CYCLES.
REQ-028 SHALL return from HIT to READY when the counter reaches 0.
REQ-029 SHALL go to INIT from any unused state encoding.

Reset
REQ-030 SHALL, when rst=0 at a clk edge, enter INIT with seg=7'b1111111, lane=START_LANE, busy=0 and counters=0.
REQ-031 SHALL let reset override any state, including mid-COOLDOWN and mid-HIT.

Configuration
REQ-032 SHALL, when PLAYER_BLINK_EN is defined, toggle seg between the lane pattern and 7'b1111111 every 2 cycles while in HIT, starting with blank.
REQ-033 SHALL, when PLAYER_BLINK_EN is undefined, show the steady lane pattern in HIT and omit the blink logic.

Verification
REQ-034 SHALL cover reset and start: rst low for 2 cycles, then high -> seg=7'b1111111 for 1 cycle, then 7'b0011100, lane=0.
REQ-035 SHALL cover saturation: LANES=2, WRAP=0, lane=1, move_down pulse -> lane stays 1, busy stays 0.
REQ-036 SHALL cover wrap: LANES=4, WRAP=1, lane=0, move_up -> lane=3, seg=7'b1111110, busy high for 4 cycles.
REQ-037 SHALL cover cooldown: move_down, then move_down 2 cycles later -> only the first move is taken, lane=1.
REQ-038 SHALL cover hit priority: hit and move_down in the same cycle -> lane unchanged, busy high for 16 cycles, seg blinks with PLAYER_BLINK_EN.
REQ-039 SHALL cover hit retrigger and mid-HIT reset: hit at cycle 10 of HIT -> busy high for 16 more cycles; rst=0 mid-HIT -> INIT on the next edge.
